clk_rst_seq: RTL and testbench

//  Parametrised clock-enable and reset sequencer for FPGA and sim tops; replaces ad-hoc clock/reset code.

---
 rtl/clk_rst_seq_pkg.sv | 23 ++
 rtl/ce_divider.sv | 34 +++
 rtl/clk_rst_seq.sv | 152 +++++++++++++++
 tb/tb_clk_rst_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_seq_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
// The watchdog is compiled in only when CLK_RST_SEQ_WATCHDOG_EN is defined.
package clk_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STAGGER,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Cycles between the release of channel 0 and the release of channel ch.
    function automatic int release_offset(input int ch, input int stagger);
        return ch * stagger;
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Per-domain clock-enable divider: strobes once every 'ratio' cycles while not cleared.
// A ratio of 0 or 1 makes the enable continuously high.
module ce_divider
    import clk_rst_seq_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] ratio,
    output logic             ce
);

    logic [DIV_W-1:0] cnt;
    logic             bypass;
    logic             hit;

    assign bypass = (ratio <= DIV_W'(1));
    assign hit    = (cnt == DIV_W'(ratio - 1'b1));
    assign ce     = !clr && (bypass || hit);

    // Counter sits at zero while the domain is in reset so the first strobe lands ratio cycles after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || bypass || hit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Clock-enable and staggered reset sequencer for FPGA and simulation tops.
// Define CLK_RST_SEQ_WATCHDOG_EN to enable the run-length watchdog and the timeout flag.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int HOLD_W    = 16,
    parameter int STAGGER   = 4,
    parameter int TIMEOUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [HOLD_W-1:0]       hold_cycles,
    input  logic [TIMEOUT_W-1:0]    timeout_cycles,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       rst_out,
    output logic                    running,
    output logic                    timeout
);

    localparam int STG_MAX = release_offset(NUM_CH - 1, STAGGER);
    localparam int STG_W   = cnt_width(STG_MAX);

    seq_state_e              state;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [HOLD_W-1:0]       hold_lat;
    logic [HOLD_W-1:0]       hold_eff;
    logic [NUM_CH*DIV_W-1:0] div_lat;
    logic [STG_W-1:0]        stg_cnt;
    logic                    stg_last;

`ifdef CLK_RST_SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0]    wd_cnt;
    logic [TIMEOUT_W-1:0]    timeout_lat;
    logic                    timeout_r;

    assign timeout = timeout_r;
`else
    logic                    unused_timeout_cycles;

    assign unused_timeout_cycles = ^timeout_cycles;
    assign timeout               = 1'b0;
`endif

    assign hold_eff = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
    assign stg_last = ((int'(stg_cnt) + 1) == STG_MAX);

    // Abort outranks every other event once a sequence has been started; IDLE ignores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rst_out  <= '1;
            running  <= 1'b0;
            hold_cnt <= '0;
            hold_lat <= '0;
            div_lat  <= '0;
            stg_cnt  <= '0;
`ifdef CLK_RST_SEQ_WATCHDOG_EN
            wd_cnt      <= '0;
            timeout_lat <= '0;
            timeout_r   <= 1'b0;
`endif
        end else if (abort && state != ST_IDLE) begin
            state    <= ST_HOLD;
            hold_cnt <= hold_lat;
            stg_cnt  <= '0;
            rst_out  <= '1;
            running  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_HOLD;
                        hold_cnt <= hold_eff;
                        hold_lat <= hold_eff;
                        div_lat  <= div_ratio;
                        stg_cnt  <= '0;
`ifdef CLK_RST_SEQ_WATCHDOG_EN
                        timeout_lat <= timeout_cycles;
                        timeout_r   <= 1'b0;
`endif
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        rst_out[0] <= 1'b0;
                        stg_cnt    <= '0;
                        if (NUM_CH == 1) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
`ifdef CLK_RST_SEQ_WATCHDOG_EN
                            wd_cnt  <= '0;
`endif
                        end else begin
                            state <= ST_STAGGER;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_STAGGER: begin
                    for (int i = 1; i < NUM_CH; i++) begin
                        if ((int'(stg_cnt) + 1) == release_offset(i, STAGGER)) begin
                            rst_out[i] <= 1'b0;
                        end
                    end
                    if (stg_last) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
`ifdef CLK_RST_SEQ_WATCHDOG_EN
                        wd_cnt  <= '0;
`endif
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
`ifdef CLK_RST_SEQ_WATCHDOG_EN
                    if (timeout_lat != '0 && wd_cnt == timeout_lat - 1'b1) begin
                        state     <= ST_DONE;
                        rst_out   <= '1;
                        running   <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_div
        ce_divider #(
            .DIV_W (DIV_W)
        ) u_div (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (rst_out[i]),
            .ratio (div_lat[i*DIV_W +: DIV_W]),
            .ce    (ce_out[i])
        );
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: a timeline model predicts every cycle's outputs.
// Honours CLK_RST_SEQ_WATCHDOG_EN the same way the design does.
module tb_clk_rst_seq;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 8;
    localparam int HOLD_W    = 16;
    localparam int STAGGER   = 4;
    localparam int TIMEOUT_W = 32;
`ifdef CLK_RST_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
    logic [HOLD_W-1:0]       hold_cycles = '0;
    logic [TIMEOUT_W-1:0]    timeout_cycles = '0;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH-1:0]       rst_out;
    logic                    running;
    logic                    timeout;

    clk_rst_seq #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .HOLD_W    (HOLD_W),
        .STAGGER   (STAGGER),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .div_ratio      (div_ratio),
        .hold_cycles    (hold_cycles),
        .timeout_cycles (timeout_cycles),
        .ce_out         (ce_out),
        .rst_out        (rst_out),
        .running        (running),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                cyc;
        logic [NUM_CH-1:0] rst;
        logic [NUM_CH-1:0] ce;
        logic              run;
        logic              tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference timeline: everything is derived from the edge at which HOLD was (re)entered.
    int  edge_no = 0;
    bit  m_active = 1'b0;
    bit  m_to = 1'b0;
    int  m_origin = 0;
    int  m_hold = 1;
    int  m_t = 0;
    int  m_div[NUM_CH];
    bit  p_start = 1'b0;
    bit  p_abort = 1'b0;
    bit  p_rst_n = 1'b0;
    logic [NUM_CH*DIV_W-1:0] p_div = '0;
    int  p_hold = 0;
    int  p_t = 0;

    logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
    int  cfg_hold = 0;
    int  cfg_t = 0;

    function automatic int rel_edge(input int ch);
        return m_origin + m_hold + 1 + ch * STAGGER;
    endfunction

    function automatic bit done_at(input int e);
        return m_active && WD_EN && (m_t != 0) && (e >= rel_edge(NUM_CH - 1) + m_t);
    endfunction

    function automatic exp_t model_out(input int e);
        exp_t r;
        r.cyc = e;
        r.rst = '1;
        r.ce  = '0;
        r.run = 1'b0;
        r.tmo = 1'b0;
        if (m_active && done_at(e)) begin
            r.tmo = 1'b1;
        end else if (m_active) begin
            r.tmo = m_to;
            r.run = (e >= rel_edge(NUM_CH - 1));
            for (int i = 0; i < NUM_CH; i++) begin
                if (e >= rel_edge(i)) begin
                    r.rst[i] = 1'b0;
                    r.ce[i]  = (m_div[i] <= 1) || (((e - rel_edge(i)) % m_div[i]) == m_div[i] - 1);
                end
            end
        end
        return r;
    endfunction

    task automatic model_step();
        bit idle_or_done;
        edge_no++;
        if (!p_rst_n) begin
            m_active = 1'b0;
            m_to     = 1'b0;
            return;
        end
        if (done_at(edge_no - 1)) m_to = 1'b1;
        idle_or_done = !m_active || done_at(edge_no - 1);
        if (p_abort && m_active) begin
            m_origin = edge_no;
        end else if (p_start && idle_or_done) begin
            m_active = 1'b1;
            m_origin = edge_no;
            m_hold   = (p_hold == 0) ? 1 : p_hold;
            m_t      = p_t;
            m_to     = 1'b0;
            for (int i = 0; i < NUM_CH; i++) m_div[i] = int'(p_div[i*DIV_W +: DIV_W]);
        end
    endtask

    // Config inputs carry the chosen values only on start cycles; otherwise noise that must be ignored.
    task automatic applyStimulus(input bit s, input bit a, input bit r);
        @(posedge clk);
        #1;
        model_step();
        start = s;
        abort = a;
        rst_n = r;
        if (s) begin
            div_ratio      = cfg_div;
            hold_cycles    = HOLD_W'(cfg_hold);
            timeout_cycles = TIMEOUT_W'(cfg_t);
        end else begin
            div_ratio      = NUM_CH*DIV_W'($urandom);
            hold_cycles    = HOLD_W'($urandom_range(40, 0));
            timeout_cycles = TIMEOUT_W'($urandom_range(40, 0));
        end
        p_start = s;
        p_abort = a;
        p_rst_n = r;
        p_div   = div_ratio;
        p_hold  = int'(hold_cycles);
        p_t     = int'(timeout_cycles);
        if (!r) begin
            m_active = 1'b0;
            m_to     = 1'b0;
        end
        exp_q.push_back(model_out(edge_no));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (rst_out !== e.rst) begin
            errors++;
            $display("[TB] FAIL rst_out cycle %0d: got %b expected %b", e.cyc, rst_out, e.rst);
        end
        checks++;
        if (ce_out !== e.ce) begin
            errors++;
            $display("[TB] FAIL ce_out cycle %0d: got %b expected %b", e.cyc, ce_out, e.ce);
        end
        checks++;
        if (running !== e.run) begin
            errors++;
            $display("[TB] FAIL running cycle %0d: got %b expected %b", e.cyc, running, e.run);
        end
        checks++;
        if (timeout !== e.tmo) begin
            errors++;
            $display("[TB] FAIL timeout cycle %0d: got %b expected %b", e.cyc, timeout, e.tmo);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        $display("[TB] start, watchdog enabled = %0d", WD_EN);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        idle_cycles(3);

        // Nominal sequence: H=10, ch0 ratio 1, ch1 ratio 5, T=20.
        cfg_div = {8'd5, 8'd1};
        cfg_hold = 10;
        cfg_t = 20;
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle_cycles(60);

        // Restart after DONE (or ignored start while RUN), then abort inside STAGGER.
        cfg_hold = 3;
        cfg_div = {8'd3, 8'd2};
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle_cycles(5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        idle_cycles(6);
        applyStimulus(1'b1, 1'b1, 1'b1);
        idle_cycles(25);

        // Reset mid-run, then H=0 and T=0 held for a long run.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        cfg_hold = 0;
        cfg_t = 0;
        cfg_div = {8'd0, 8'd4};
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle_cycles(10050);

        // Watchdog length 20 started from a clean reset.
        applyStimulus(1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        cfg_hold = 2;
        cfg_t = 20;
        applyStimulus(1'b1, 1'b0, 1'b1);
        idle_cycles(40);
        applyStimulus(1'b0, 1'b0, 1'b0);
        idle_cycles(2);

        // Randomised episodes with stray starts, aborts and resets.
        for (int ep = 0; ep < 40; ep++) begin
            cfg_hold = $urandom_range(12, 0);
            cfg_t    = $urandom_range(30, 0);
            for (int i = 0; i < NUM_CH; i++) cfg_div[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(7, 0));
            applyStimulus(1'b1, 1'b0, 1'b1);
            for (int c = 0; c < int'($urandom_range(60, 5)); c++) begin
                if ($urandom_range(199, 0) == 0) begin
                    applyStimulus(1'b0, 1'b0, 1'b0);
                end else begin
                    applyStimulus($urandom_range(9, 0) == 0, $urandom_range(24, 0) == 0, 1'b1);
                end
            end
        end

        idle_cycles(2);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
